// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling, 3-sample majority voting per bit,
// optional parity, one or two stop bits, break detection and a
// valid/ready output holding register with sticky overrun reporting.
module uart_rx_oversampled #(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       data_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop_sel_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       parity_err_o,
  output logic       framing_err_o,
  output logic       overrun_err_o,
  output logic       break_o
);

  // Clocks per oversample tick, rounded to nearest, never below one.
  localparam int DIV_R = (p_clk_speed_hz + 8 * p_baud_rate) / (16 * p_baud_rate);
  localparam int DIV_C = (DIV_R < 1) ? 1 : DIV_R;
  localparam int DIV_W = (DIV_C > 1) ? $clog2(DIV_C) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             sync_p0, sync_p1, line_prev;
  logic             line;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic             s7, s8;
  logic [7:0]       shreg;
  logic             par_bit_q, stop1_bad_q;
  logic             par_en_q, par_sel_q, stop_sel_q;
  logic             eof_p, ferr_p, brk_p;
  logic             tick, samp, bit_end, maj, start_edge, last_stop;
  logic             ferr_now, stop1_low, brk_now, perr, handshake, deliver;

  assign line       = sync_p1;
  assign tick       = (div_cnt == DIV_W'(DIV_C - 1));
  assign samp       = tick && (tick_cnt == 4'd9);
  assign bit_end    = tick && (tick_cnt == 4'd15);
  assign maj        = (s7 & s8) | (s7 & line) | (s8 & line);
  assign start_edge = (state_q == IDLE) && enable_i && line_prev && !line;
  assign last_stop  = samp && (((state_q == STOP1) && !stop_sel_q) || (state_q == STOP2));
  assign ferr_now   = !maj || ((state_q == STOP2) && stop1_bad_q);
  assign stop1_low  = (state_q == STOP1) ? !maj : stop1_bad_q;
  assign brk_now    = (shreg == 8'd0) && !(par_en_q && par_bit_q) && stop1_low;
  assign perr       = par_en_q && ((^shreg ^ par_bit_q) != par_sel_q);
  assign handshake  = valid_o && ready_i;
  assign deliver    = eof_p && enable_i && !brk_p;
  assign busy_o     = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; START decides at mid-bit, stop bits end the frame at their vote.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start_edge) state_d = START;
        START: begin
          if (tick && (tick_cnt == 4'd8) && line) state_d = IDLE;
          else if (bit_end)                       state_d = DATA;
        end
        DATA:      if (bit_end && (bit_cnt == 3'd7)) state_d = par_en_q ? PARITY : STOP1;
        PARITY:    if (bit_end) state_d = STOP1;
        STOP1: begin
          if (last_stop)    state_d = ferr_now ? WAIT_HIGH : IDLE;
          else if (bit_end) state_d = STOP2;
        end
        STOP2:     if (last_stop) state_d = ferr_now ? WAIT_HIGH : IDLE;
        WAIT_HIGH: if (line) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Control: synchronizer, tick divider, bit counters, end-of-frame and output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0       <= 1'b1;
      sync_p1       <= 1'b1;
      line_prev     <= 1'b1;
      div_cnt       <= '0;
      tick_cnt      <= 4'd0;
      bit_cnt       <= 3'd0;
      eof_p         <= 1'b0;
      ferr_p        <= 1'b0;
      brk_p         <= 1'b0;
      data_o        <= 8'h00;
      valid_o       <= 1'b0;
      parity_err_o  <= 1'b0;
      framing_err_o <= 1'b0;
      overrun_err_o <= 1'b0;
      break_o       <= 1'b0;
    end else begin
      sync_p0   <= data_i;
      sync_p1   <= sync_p0;
      line_prev <= line;

      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;

      if (start_edge) tick_cnt <= 4'd0;
      else if (tick)  tick_cnt <= tick_cnt + 4'd1;

      if (start_edge)                            bit_cnt <= 3'd0;
      else if (bit_end && (state_q == DATA))     bit_cnt <= bit_cnt + 3'd1;

      eof_p  <= last_stop && enable_i;
      ferr_p <= ferr_now;
      brk_p  <= brk_now;

      break_o <= eof_p && enable_i && brk_p;

      if (deliver) begin
        if (valid_o && !ready_i) begin
          overrun_err_o <= 1'b1;
        end else begin
          data_o        <= shreg;
          parity_err_o  <= perr;
          framing_err_o <= ferr_p;
          valid_o       <= 1'b1;
          if (handshake) overrun_err_o <= 1'b0;
        end
      end else if (handshake) begin
        valid_o       <= 1'b0;
        overrun_err_o <= 1'b0;
      end
    end
  end

  // Datapath: vote samples, shift register, parity/stop capture, frame config latch.
  always_ff @(posedge clk_i) begin
    if (tick && (tick_cnt == 4'd7)) s7 <= line;
    if (tick && (tick_cnt == 4'd8)) s8 <= line;
    if (samp && (state_q == DATA))   shreg       <= {maj, shreg[7:1]};
    if (samp && (state_q == PARITY)) par_bit_q   <= maj;
    if (samp && (state_q == STOP1))  stop1_bad_q <= !maj;
    if (start_edge) begin
      par_en_q   <= parity_en_i;
      par_sel_q  <= parity_sel_i;
      stop_sel_q <= stop_sel_i;
    end
  end

endmodule
